// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue between the MMIO UART TX register and the uart_tx
// serializer. Stores are absorbed into a DEPTH-entry circular buffer and
// drained one byte per frame through a start/busy handshake with uart_tx.
// A launch whose busy flag never rises is abandoned after BUSY_TIMEOUT cycles
// so the drain can never hang.
// Optional build macro UART_FIFO_STATS_EN adds tx_count / drop_count counters.
module uart_tx_fifo #(
    parameter  int DEPTH        = 16,
    parameter  int BUSY_TIMEOUT = 4,
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy
`ifdef UART_FIFO_STATS_EN
    ,
    output logic [31:0]      tx_count,
    output logic [15:0]      drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;
    logic [7:0]       r_tx_data;
    logic [TMR_W-1:0] r_timer;
    state_t           r_state;

    state_t           w_next_state;
    logic             w_push;
    logic             w_pop;
    logic             w_reject;
    logic             w_load;
    logic             w_timer_clr;
    logic             w_timer_inc;
    logic [CNT_W-1:0] w_count_next;

    // Push/pop qualification uses the registered (pre-edge) full flag, so a
    // push while full is rejected even when a pop happens in the same cycle.
    assign w_push   = wr_en && !r_full;
    assign w_reject = wr_en &&  r_full;
    assign w_pop    = (r_state == LAUNCH);

    // Next occupancy; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Drain FSM next-state and launch decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (which would infer a latch).
        w_next_state = r_state;
        tx_start     = 1'b0;
        w_load       = 1'b0;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_empty && !tx_busy) begin
                    w_load       = 1'b1;
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start     = 1'b1;
                w_timer_clr  = 1'b1;
                w_next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_next_state = WAIT_DONE;
                end else if (r_timer == TMR_LAST) begin
                    // uart_tx never acknowledged: treat the byte as sent.
                    w_next_state = IDLE;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; pointers and count define validity, and leaving it out keeps it mappable to RAM.
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy flags, overflow flag, FSM state, timer and tx_data.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_tx_data  <= 8'h00;
            r_timer    <= '0;
            r_state    <= IDLE;
        end else begin
            r_state <= w_next_state;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            // Set wins over a simultaneous clear.
            if (w_reject) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end

            if (w_load) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end

            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_data  = r_tx_data;

`ifdef UART_FIFO_STATS_EN
    logic [31:0] r_tx_count;
    logic [15:0] r_drop_count;

    // Launch counter wraps; drop counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pop) begin
                r_tx_count <= r_tx_count + 32'd1;
            end
            if (w_reject && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign tx_count   = r_tx_count;
    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo. Inputs are driven and outputs sampled
// on the falling edge; the DUT acts on the rising edge. A small uart_tx model
// raises busy the edge after tx_start and holds it for FRAME cycles, and a
// monitor records every launched byte.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;
    localparam int FRAME = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             clr_overflow = 1'b0;
    logic             tx_busy_force = 1'b0;
    logic             model_en = 1'b0;
    logic             model_busy = 1'b0;
    logic             tx_busy;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             tx_start;
    logic [7:0]       tx_data;
`ifdef UART_FIFO_STATS_EN
    logic [31:0]      tx_count;
    logic [15:0]      drop_count;
`endif

    int         errors = 0;
    int         checks = 0;
    int         frame_left = 0;
    logic [7:0] launched [$];

    assign tx_busy = tx_busy_force | model_busy;

    uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy)
`ifdef UART_FIFO_STATS_EN
        ,
        .tx_count     (tx_count),
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    // uart_tx model: busy rises the edge after tx_start and lasts FRAME cycles.
    always @(posedge clk) begin
        if (rst) begin
            model_busy <= 1'b0;
            frame_left <= 0;
        end else if (model_en && tx_start) begin
            model_busy <= 1'b1;
            frame_left <= FRAME;
        end else if (frame_left > 1) begin
            frame_left <= frame_left - 1;
        end else begin
            frame_left <= 0;
            model_busy <= 1'b0;
        end
    end

    // Launch monitor.
    always @(posedge clk) begin
        if (rst !== 1'b1 && tx_start === 1'b1) launched.push_back(tx_data);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; clr_overflow = 1'b0;
        tx_busy_force = 1'b0; model_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        launched.delete();
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Waits (bounded) until n bytes have launched and the drain has settled.
    task automatic wait_drain(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (launched.size() >= n && empty && !tx_busy && !tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (tx_start !== 1'b0)  begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    endtask

    task automatic test_single_launch();
        do_reset();
        push_byte(8'h41);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_no_bypass: tx_start got %b expected 0", tx_start); end
        checks++; if (count !== 5'd1)    begin errors++; $display("FAIL single_count1: got %0d expected 1", count); end
        checks++; if (empty !== 1'b0)    begin errors++; $display("FAIL single_empty0: got %b expected 0", empty); end
        tick();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_latency: tx_start got %b expected 1", tx_start); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_tx_data: got %h expected 41", tx_data); end
        checks++; if (count !== 5'd1)    begin errors++; $display("FAIL single_count_launch: got %0d expected 1", count); end
        tick();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_one_pulse: tx_start got %b expected 0", tx_start); end
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL single_count0: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL single_empty1: got %b expected 1", empty); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_tx_data_hold: got %h expected 41", tx_data); end
        repeat (8) tick();
        checks++; if (launched.size() != 1) begin errors++; $display("FAIL single_launch_count: got %0d expected 1", launched.size()); end
    endtask

    task automatic test_fill_overflow();
        bit ok;
        do_reset();
        tx_busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
        checks++; if (count !== 5'd16)   begin errors++; $display("FAIL fill_count: got %0d expected 16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow: got %b expected 0", overflow); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL fill_busy_hold: tx_start got %b expected 0", tx_start); end
        push_byte(8'hAA);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (count !== 5'd16)   begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
        // rejected push together with a clear: set must win
        wr_en = 1'b1; wr_data = 8'hBB; clr_overflow = 1'b1;
        tick();
        wr_en = 1'b0; clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        model_en = 1'b1; tx_busy_force = 1'b0;
        wait_drain(16, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drain_timeout: drained %0d expected 16", launched.size()); end
        checks++; if (launched.size() != 16) begin errors++; $display("FAIL drain_size: got %0d expected 16", launched.size()); end
        for (int i = 0; i < 16 && i < launched.size(); i++) begin
            checks++;
            if (launched[i] !== 8'(i)) begin errors++; $display("FAIL drain_order[%0d]: got %h expected %h", i, launched[i], 8'(i)); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
        model_en = 1'b0;
    endtask

    task automatic test_full_pop_collision();
        bit ok;
        do_reset();
        tx_busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        tx_busy_force = 1'b0;
        tick();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL coll_launch: tx_start got %b expected 1", tx_start); end
        checks++; if (tx_data !== 8'h20) begin errors++; $display("FAIL coll_tx_data: got %h expected 20", tx_data); end
        push_byte(8'h55);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coll_overflow: got %b expected 1", overflow); end
        checks++; if (count !== 5'd15)   begin errors++; $display("FAIL coll_count: got %0d expected 15", count); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL coll_full: got %b expected 0", full); end
        model_en = 1'b1;
        wait_drain(16, ok);
        checks++; if (!ok) begin errors++; $display("FAIL coll_drain_timeout: drained %0d expected 16", launched.size()); end
        checks++; if (launched.size() != 16) begin errors++; $display("FAIL coll_drain_size: got %0d expected 16", launched.size()); end
        for (int i = 0; i < 16 && i < launched.size(); i++) begin
            checks++;
            if (launched[i] !== 8'h20 + 8'(i)) begin errors++; $display("FAIL coll_order[%0d]: got %h expected %h", i, launched[i], 8'h20 + 8'(i)); end
        end
        model_en = 1'b0;
    endtask

    task automatic test_busy_timeout();
        int gap;
        do_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_first_launch: tx_start got %b expected 1", tx_start); end
        checks++; if (tx_data !== 8'h11) begin errors++; $display("FAIL to_first_data: got %h expected 11", tx_data); end
        gap = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (tx_start) begin gap = i; break; end
        end
        checks++; if (gap != 6)          begin errors++; $display("FAIL to_gap: got %0d cycles expected 6", gap); end
        checks++; if (tx_data !== 8'h22) begin errors++; $display("FAIL to_second_data: got %h expected 22", tx_data); end
        checks++; if (count !== 5'd1)    begin errors++; $display("FAIL to_count: got %0d expected 1", count); end
        repeat (10) tick();
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL to_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        model_en = 1'b1;
        for (int i = 0; i < 6; i++) push_byte(8'h30 + 8'(i));
        checks++; if (count !== 5'd5)   begin errors++; $display("FAIL mid_pre_count: got %0d expected 5", count); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %b expected 1", tx_busy); end
        rst = 1'b1;
        tick();
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL mid_empty: got %b expected 1", empty); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start: got %b expected 0", tx_start); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data: got %h expected 00", tx_data); end
        rst = 1'b0;
        launched.delete();
        push_byte(8'h77);
        tick();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL mid_idle_launch: tx_start got %b expected 1", tx_start); end
        checks++; if (tx_data !== 8'h77) begin errors++; $display("FAIL mid_idle_data: got %h expected 77", tx_data); end
        repeat (15) tick();
        model_en = 1'b0;
    endtask

`ifdef UART_FIFO_STATS_EN
    task automatic test_stats();
        bit ok;
        do_reset();
        tx_busy_force = 1'b1;
        for (int i = 0; i < 20; i++) push_byte(8'h60 + 8'(i));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stats_clr: got %b expected 0", overflow); end
        model_en = 1'b1; tx_busy_force = 1'b0;
        wait_drain(16, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stats_drain_timeout: drained %0d expected 16", launched.size()); end
        checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL stats_drop: got %0d expected 4", drop_count); end
        checks++; if (tx_count !== 32'd16)  begin errors++; $display("FAIL stats_tx: got %0d expected 16", tx_count); end
        model_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_launch();
        test_fill_overflow();
        test_full_pop_collision();
        test_busy_timeout();
        test_reset_mid_frame();
`ifdef UART_FIFO_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer between the data-memory MMIO UART TX register (0x80000004) and the uart_tx serializer.
- Absorbs CPU bursts so stores issued while the serializer is busy are queued instead of dropped.
- Drains one byte per uart_tx frame using a start/busy handshake.
- Exposes full/empty/count status for MMIO polling.

Parameters:
DEPTH, 16, number of byte entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of count output (derived, not overridden)
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after a launch before abandoning the wait

Ports:
clk  in  1  clock
rst  in  1  reset
wr_en  in  1  push request from MMIO store decode
wr_data  in  8  byte to queue
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  CNT_W  occupied entries
overflow  out  1  sticky: a push was rejected because the FIFO was full
clr_overflow  in  1  clears overflow
tx_start  out  1  one-cycle launch pulse to uart_tx
tx_data  out  8  byte presented to uart_tx, registered
tx_busy  in  1  uart_tx busy flag

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset:
  - read/write pointers, count = 0; empty = 1; full = 0; overflow = 0
  - tx_start = 0; tx_data = 8'h00; state = IDLE
  - Queued bytes are discarded. Reset mid-frame is legal, since uart_tx shares rst.
- Push: accepted at the clk edge when wr_en && !full. Data is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
- full is evaluated on pre-edge state. A push while full is rejected even if a pop happens in the same cycle.
- Rejected push (wr_en && full): overflow is set. clr_overflow clears it. Set wins over a simultaneous clear. Queue contents are unchanged.
- Pop: occurs only on the LAUNCH -> WAIT_BUSY edge. rd_ptr wraps modulo DEPTH.
- Push and pop in the same cycle (not full): count is unchanged and both pointers advance.
- count, full and empty are registered and consistent with each other on every cycle.
- There is no bypass. A byte pushed into an empty FIFO becomes launchable the cycle after its write edge.
- Drain FSM:
  - IDLE: if !empty && !tx_busy, load tx_data <= mem[rd_ptr] and go to LAUNCH.
  - LAUNCH: tx_start = 1 for exactly this one cycle, then pop and go to WAIT_BUSY (timer cleared).
  - WAIT_BUSY: if tx_busy, go to WAIT_DONE. Otherwise increment the timer; when timer == BUSY_TIMEOUT-1, go to IDLE (byte counts as sent, no retry).
  - WAIT_DONE: when !tx_busy, go to IDLE.
- Latency: a push accepted at edge N gives tx_start high in the cycle after edge N+1 (2 cycles). Back-to-back bytes are separated by the uart_tx frame time + 2 cycles.
- tx_data holds its value from the IDLE->LAUNCH edge until the next load.
- tx_start is never asserted while tx_busy = 1 in IDLE.
- Entries are never read while empty and never overwritten while full.

Optional Feature:
UART_FIFO_STATS_EN
- Defined: adds two output ports, both cleared by rst.
  - tx_count (32 bits): increments on every LAUNCH cycle and wraps.
  - drop_count (16 bits): increments on every rejected push and saturates at 16'hFFFF.
- Not defined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then push 8'h41 with tx_busy held 0 -> tx_start high exactly 2 cycles after the write edge, tx_data = 8'h41; count goes 1 -> 0 after LAUNCH.
- Push 16 bytes 8'h00..8'h0F while tx_busy held 1 -> full = 1, count = 16; a 17th push sets overflow and the queue is unchanged. Then drive tx_busy from a uart_tx model -> bytes emerge in order 00..0F and empty = 1 at the end.
- Full FIFO, wr_en coincident with a pop edge -> push rejected, overflow = 1, count = 15 afterwards.
- Launch with tx_busy never rising -> FSM returns to IDLE after BUSY_TIMEOUT = 4 cycles and the next byte launches; no hang.
- Assert rst while in WAIT_DONE with 5 bytes queued -> next cycle count = 0, empty = 1, tx_start = 0, overflow = 0, state IDLE.
- UART_FIFO_STATS_EN defined, 20 pushes into a stalled FIFO, then drain -> drop_count = 4, tx_count = 16; overflow cleared by clr_overflow while the set condition is absent.
